// File: rtl/formula_result_drain.sv
// Credit-based valid/ready shell around the non-backpressuring sqrt(a+sqrt(b+sqrt(c))) pipe.
// Define FORMULA_RESULT_DRAIN_BYPASS_EN to let a result pass straight through when the buffer is empty.
module formula_result_drain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [WIDTH-1:0]           in_c,
  output logic                       pipe_arg_vld,
  output logic [WIDTH-1:0]           pipe_a,
  output logic [WIDTH-1:0]           pipe_b,
  output logic [WIDTH-1:0]           pipe_c,
  input  logic                       pipe_res_vld,
  input  logic [WIDTH-1:0]           pipe_res,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       err_unexpected
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] r_inflt;
  logic [OCC_W-1:0] r_cnt;
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic             r_err;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_accept;
  logic w_res_ok;
  logic w_unexp;
  logic w_empty;
  logic w_byp;
  logic w_pop;
  logic w_wr;
  logic w_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [OCC_W-1:0] cnt_upd(input logic [OCC_W-1:0] c,
                                               input logic inc, input logic dec);
    case ({inc, dec})
      2'b10:   return c + OCC_W'(1);
      2'b01:   return c - OCC_W'(1);
      default: return c;
    endcase
  endfunction

  // Credit check uses only registered occupancy, so in_ready never sees out_ready or pipe_res_vld.
  assign in_ready     = ~rst & (r_occ < OCC_W'(DEPTH));
  assign w_accept     = in_valid & in_ready;
  assign pipe_arg_vld = w_accept;
  assign pipe_a       = in_a;
  assign pipe_b       = in_b;
  assign pipe_c       = in_c;

  assign w_res_ok = pipe_res_vld & (r_inflt != '0);
  assign w_unexp  = pipe_res_vld & (r_inflt == '0);
  assign w_empty  = (r_cnt == '0);

`ifdef FORMULA_RESULT_DRAIN_BYPASS_EN
  assign w_byp     = w_empty & w_res_ok & out_ready;
  assign out_valid = ~w_empty | w_res_ok;
  assign out_data  = w_empty ? pipe_res : r_mem[r_rptr];
`else
  assign w_byp     = 1'b0;
  assign out_valid = ~w_empty;
  assign out_data  = r_mem[r_rptr];
`endif

  assign w_pop = out_valid & out_ready;
  assign w_wr  = w_res_ok & ~w_byp;
  // A bypassed result is popped without ever touching the buffer.
  assign w_rd  = w_pop & ~w_empty;

  assign occupancy      = r_occ;
  assign err_unexpected = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ   <= '0;
      r_inflt <= '0;
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_occ   <= cnt_upd(r_occ, w_accept, w_pop);
      r_inflt <= cnt_upd(r_inflt, w_accept, w_res_ok);
      r_cnt   <= cnt_upd(r_cnt, w_wr, w_rd);
      if (w_wr) r_wptr <= ptr_inc(r_wptr);
      if (w_rd) r_rptr <= ptr_inc(r_rptr);
      if (w_unexp) r_err <= 1'b1;
    end
  end

  // Data storage carries no reset; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= pipe_res;
  end

endmodule

// File: tb/tb_formula_result_drain.sv
// Bench for formula_result_drain: behavioural fixed-latency formula pipe plus a scoreboard queue.
`timescale 1ns/1ps
module tb_formula_result_drain;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int LAT   = 4;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b, in_c;
  logic pipe_arg_vld;
  logic [WIDTH-1:0] pipe_a, pipe_b, pipe_c;
  logic pipe_res_vld;
  logic [WIDTH-1:0] pipe_res;
  logic out_valid, out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;
  logic err_unexpected;

  logic frc_vld = 1'b0;
  logic [WIDTH-1:0] frc_dat = '0;
  logic [LAT-1:0] pv;
  logic [WIDTH-1:0] pd [LAT];

  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_pop = 0;
  logic [WIDTH-1:0] q [$];

  always #5 clk = ~clk;

  formula_result_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .pipe_arg_vld(pipe_arg_vld),
    .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c),
    .pipe_res_vld(pipe_res_vld), .pipe_res(pipe_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .err_unexpected(err_unexpected)
  );

  function automatic longint unsigned isqrt(input longint unsigned x);
    longint unsigned r, t;
    r = 0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= x) r = t;
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] formula(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
    longint unsigned s;
    s = isqrt(64'(c));
    s = isqrt(64'(b) + s);
    s = isqrt(64'(a) + s);
    return WIDTH'(s);
  endfunction

  // Reference pipe: valid-only, in order, LAT cycles, reset by the shared rst.
  always_ff @(posedge clk) begin
    if (rst) pv <= '0;
    else     pv <= {pv[LAT-2:0], pipe_arg_vld};
    pd[0] <= formula(pipe_a, pipe_b, pipe_c);
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
  end
  assign pipe_res_vld = pv[LAT-1] | frc_vld;
  assign pipe_res     = frc_vld ? frc_dat : pd[LAT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] c);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_c = c;
    step();
  endtask

  task automatic wait_idle(input int n);
    int k;
    k = 0;
    while ((occupancy != 0 || q.size() != 0) && k < n) begin
      @(negedge clk);
      k++;
    end
    chk("drain_done", 64'(occupancy), 0);
    step();
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  initial begin
    logic hold_v;
    logic [WIDTH-1:0] hold_d;
    hold_v = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        hold_v = 1'b0;
      end else begin
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
        if (hold_v) begin
          chk("hold_valid", 64'(out_valid), 1);
          chk("hold_data", 64'(out_data), 64'(hold_d));
        end
        if (in_valid && in_ready) begin
          q.push_back(formula(in_a, in_b, in_c));
          n_acc++;
        end
        if (out_valid && out_ready) begin
          n_pop++;
          if (q.size() == 0) chk("pop_expected", 0, 1);
          else chk("out_data", 64'(out_data), 64'(q.pop_front()));
        end
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, a0, rv, ov, olast, ocnt, k;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0; out_ready = 1'b0;
    step();
    in_valid = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_arg_vld", 64'(pipe_arg_vld), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_occupancy", 64'(occupancy), 0);
    chk("rst_err", 64'(err_unexpected), 0);
    step();
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 1);

    // Single op
    step();
    out_ready = 1'b1;
    p0 = n_pop;
    send(0, 0, 16);
    in_valid = 1'b0;
    wait_idle(30);
    chk("single_pops", 64'(n_pop - p0), 1);
    chk("single_err", 64'(err_unexpected), 0);

    // Back-to-back
    p0 = n_pop;
    send(9, 5, 16);
    send(0, 0, 16);
    send(0, 0, 0);
    in_valid = 1'b0;
    rv = -1; ov = -1; olast = -1; ocnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pipe_res_vld && rv < 0) rv = c;
      if (out_valid) begin
        if (ov < 0) ov = c;
        olast = c;
        ocnt++;
      end
    end
`ifdef FORMULA_RESULT_DRAIN_BYPASS_EN
    chk("b2b_latency", 64'(ov - rv), 0);
`else
    chk("b2b_latency", 64'(ov - rv), 1);
`endif
    chk("b2b_count", 64'(ocnt), 3);
    chk("b2b_span", 64'(olast - ov), 2);
    step();
    wait_idle(30);
    chk("b2b_pops", 64'(n_pop - p0), 3);

    // Backpressure
    out_ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 20; i++) send(WIDTH'(i * 11), WIDTH'(i * 3), WIDTH'(i * 7 + 1));
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepts", 64'(n_acc - a0), DEPTH);
    chk("bp_in_ready", 64'(in_ready), 0);
    chk("bp_occupancy", 64'(occupancy), DEPTH);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_first_pop_valid", 64'(out_valid), 1);
    chk("bp_ready_same_cycle", 64'(in_ready), 0);
    @(negedge clk);
    chk("bp_ready_next_cycle", 64'(in_ready), 1);
    step();
    wait_idle(30);

    // Full buffer with simultaneous pop and write
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) send(WIDTH'(i + 100), WIDTH'(i), WIDTH'(i * i));
    in_valid = 1'b0;
    repeat (LAT + 2) step();
    chk("full_pre_occ", 64'(occupancy), DEPTH - 1);
    send(200, 300, 400);
    in_valid = 1'b0;
    k = 0;
    while (!pipe_res_vld && k < 20) begin
      step();
      k++;
    end
    chk("full_res_seen", 64'(pipe_res_vld), 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("full_occ_before", 64'(occupancy), DEPTH);
    step();
    out_ready = 1'b0;
    chk("full_occ_after", 64'(occupancy), DEPTH - 1);
    out_ready = 1'b1;
    wait_idle(40);

    // Unexpected result
    frc_vld = 1'b1;
    frc_dat = 32'hDEAD;
    @(negedge clk);
    chk("unexp_out_valid", 64'(out_valid), 0);
    step();
    frc_vld = 1'b0;
    @(negedge clk);
    chk("unexp_err_set", 64'(err_unexpected), 1);
    chk("unexp_out_valid_after", 64'(out_valid), 0);
    repeat (3) step();
    chk("unexp_err_sticky", 64'(err_unexpected), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("unexp_err_cleared", 64'(err_unexpected), 0);
    step();

    // Reset mid-stream
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(WIDTH'(i + 7), WIDTH'(i + 1), WIDTH'(i + 2));
    in_valid = 1'b0;
    repeat (LAT + 2) step();
    chk("mid_occ_before", 64'(occupancy), 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_out_valid", 64'(out_valid), 0);
    chk("mid_occupancy", 64'(occupancy), 0);
    chk("mid_in_ready", 64'(in_ready), 1);
    step();
    out_ready = 1'b1;
    p0 = n_pop;
    repeat (10) step();
    chk("mid_no_stale", 64'(n_pop - p0), 0);

    // Random traffic with random backpressure
    a0 = n_acc;
    p0 = n_pop;
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = WIDTH'($urandom_range(0, 100000));
      in_b      = WIDTH'($urandom_range(0, 100000));
      in_c      = WIDTH'($urandom_range(0, 100000));
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle(60);
    chk("rand_conserve", 64'(n_pop - p0), 64'(n_acc - a0));
    chk("rand_err", 64'(err_unexpected), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/formula_result_drain.md
# formula_result_drain

Credit-based flow-control shell for the valid-only `sqrt(a + sqrt(b + sqrt(c)))` pipeline, which has no backpressure. The block issues arguments into the pipe only while space is reserved for their results. It captures every `res_vld` pulse into an internal result buffer and presents results downstream on a valid/ready interface. It sits between a backpressuring producer/consumer pair and the pipe's `arg_vld`/`res_vld` ports, and guarantees that no result is ever lost.

## Interface
- `WIDTH`, 32: argument and result data width.
- `DEPTH`, 8: result buffer entries, which is also the maximum number of outstanding results (≥2).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high. Shared with the pipe.
- `in_valid` in 1: upstream argument triple valid.
- `in_ready` out 1: argument accepted this cycle if high together with `in_valid`.
- `in_a`, `in_b`, `in_c` in WIDTH: argument triple.
- `pipe_arg_vld` out 1: drives the pipe's `arg_vld`.
- `pipe_a`, `pipe_b`, `pipe_c` out WIDTH: combinational pass-through of `in_a`/`in_b`/`in_c`.
- `pipe_res_vld` in 1: pipe result valid.
- `pipe_res` in WIDTH: pipe result.
- `out_valid` out 1: result available downstream.
- `out_ready` in 1: downstream accepts.
- `out_data` out WIDTH: head result.
- `occupancy` out $clog2(DEPTH+1): in-flight plus buffered results.
- `err_unexpected` out 1: sticky; a result arrived with nothing in flight.

## Operation
- Accept: `accept = in_valid & in_ready`. `pipe_arg_vld = accept`.
- `in_ready = !rst & (occupancy < DEPTH)`, derived from registered state only. It has no combinational path from `out_ready` or `pipe_res_vld`.
- Counters:
  - `occupancy` increments on `accept` and decrements on downstream pop (`out_valid & out_ready`). Both in one cycle leaves it unchanged.
  - `in_flight` increments on `accept` and decrements on `pipe_res_vld`. Both in one cycle leaves it unchanged.
  - Invariant: `occupancy = in_flight + buffer count ≤ DEPTH`.
- Result buffer: circular FIFO of DEPTH entries, with read/write pointers that wrap at DEPTH−1 → 0 (DEPTH need not be a power of two).
  - Write on `pipe_res_vld` (except in the bypass case, see Configuration).
  - Read on pop.
  - Simultaneous write and read is legal at any fill level, including full, because the pop frees the slot being written.
  - By construction, a write never finds the buffer full while `in_flight > 0`.
- Unexpected result (`pipe_res_vld` with `in_flight == 0`):
  - Set `err_unexpected`.
  - Drop the data; counters and buffer are unchanged.
  - The flag clears only on `rst`.
- `out_data` holds the head entry. It is stable while `out_valid & !out_ready`.

## Timing
- Reset values:
  - `in_ready` 0 while `rst` is high, 1 in the first cycle after.
  - `pipe_arg_vld` 0, `out_valid` 0, `occupancy` 0, `err_unexpected` 0.
  - Pointers and `in_flight` are 0. Buffer contents are don't-care.
- Reset mid-operation: all state clears in one cycle and buffered results are discarded. The pipe is reset by the same `rst`, so no stale results return.
- Issue latency: an argument is accepted and presented to the pipe in the same cycle (combinational).
- Result latency, without bypass: `pipe_res_vld` at cycle N gives `out_valid` at N+1.
- Credit return: a pop at cycle N raises `in_ready` at N+1 at the earliest.
- Throughput: one argument per cycle sustained while `out_ready` stays high and `DEPTH` ≥ pipe latency + 1.
- Order: results leave in acceptance order. The pipe is in-order.

## Configuration
- `FORMULA_RESULT_DRAIN_BYPASS_EN` defined:
  - `out_valid = !empty | pipe_res_vld`.
  - When the buffer is empty, `out_data = pipe_res`. An arriving result with `out_ready` high goes out in the same cycle and is not written.
  - `occupancy` and `in_flight` both decrement in that cycle.
- Undefined:
  - `out_valid = !empty` (registered).
  - Every result is written and appears one cycle later.
  - There is no combinational path from `pipe_*` to `out_*`.

## Test plan
Bench drives the block plus the real pipe.
- Single op: `a=0, b=0, c=16`, `out_ready=1` → one `out_valid` pulse with `out_data=1`. `occupancy` returns to 0 and `err_unexpected` stays 0.
- Back-to-back: `(9,5,16)`, `(0,0,16)`, `(0,0,0)` on consecutive cycles → outputs `3`, `1`, `0` in order, one per cycle. Without bypass, the first output appears exactly one cycle after its `pipe_res_vld`.
- Backpressure: `out_ready=0`, `in_valid` held high → exactly DEPTH=8 accepts, then `in_ready=0` with `occupancy=8`. Raising `out_ready` drains 8 results in order, and `in_ready` returns one cycle after the first pop.
- Full with simultaneous pop/write: buffer at 7 entries + 1 in flight, `out_ready=1` in the cycle the last result arrives → no loss and `occupancy` drops by 1.
- Unexpected result: force `pipe_res_vld` with `in_flight=0` → `err_unexpected=1` sticky, `out_valid` stays 0. A later `rst` clears it.
- Reset mid-stream: `rst` with 5 results buffered → the next cycle shows `out_valid=0`, `occupancy=0`, `in_ready=1`, and no stale output afterwards.
